// File: rtl/adder_accum_ctrl_pkg.sv
// Shared definitions for the adder/accumulator slice.
//   LANES, LANE_W : input beat geometry (16 lanes of signed 16-bit)
//   SUM_W         : width of the per-beat lane sum
//   ACC_W         : width of the job accumulator / result
//   LEN_W         : width of the job length field (0 encodes 256)
//   state_e       : controller state encoding
package adder_pkg;

   localparam int unsigned LANES  = 16;
   localparam int unsigned LANE_W = 16;
   localparam int unsigned SUM_W  = 20;
   localparam int unsigned ACC_W  = 28;
   localparam int unsigned LEN_W  = 8;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StDrain = 2'd2,
      StOut   = 2'd3
   } state_e;

   // Sign-extend a lane sum to accumulator width.
   function automatic logic [ACC_W-1:0] sext_sum(input logic [SUM_W-1:0] s);
      return {{(ACC_W-SUM_W){s[SUM_W-1]}}, s};
   endfunction

endpackage

// File: rtl/adder_accum_ctrl_if.sv
// Job/stream/result bundle for adder_accum_ctrl.
//   start, len              : job request (len=0 means 256 beats)
//   s_valid, s_data, s_ready: input beat stream
//   m_valid, m_data, m_ready: job result
//   busy                    : controller not idle
// Modports: slave = the accumulator block, master = the driving side.
interface adder_accum_ctrl_if;
   import adder_pkg::*;

   logic                    start;
   logic [LEN_W-1:0]        len;
   logic                    s_valid;
   logic [LANES*LANE_W-1:0] s_data;
   logic                    s_ready;
   logic                    m_valid;
   logic [ACC_W-1:0]        m_data;
   logic                    m_ready;
   logic                    busy;

   modport slave (
      input  start, len, s_valid, s_data, m_ready,
      output s_ready, m_valid, m_data, busy
   );

   modport master (
      output start, len, s_valid, s_data, m_ready,
      input  s_ready, m_valid, m_data, busy
   );

endinterface

// File: rtl/adder_accum_ctrl_adder.sv
// Combinational 16-lane signed adder.
//   data : 16 signed 16-bit lanes, lane i = data[16i+15:16i]
//   sum  : signed 20-bit sum of all lanes (cannot overflow)
module adder_16b_20b
   import adder_pkg::*;
(
   input  logic [LANES*LANE_W-1:0] data,
   output logic [SUM_W-1:0]        sum
);

   always_comb begin
      sum = '0;
      for (int i = 0; i < LANES; i++) begin
         sum = sum + {{(SUM_W-LANE_W){data[i*LANE_W+LANE_W-1]}}, data[i*LANE_W +: LANE_W]};
      end
   end

endmodule

// File: rtl/adder_accum_ctrl.sv
// Reduction job controller: sums every lane of len input beats into one signed result.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : job request, input beat stream, result handshake and busy flag
// Pipeline: beat -> lane sum registered into p_sum -> folded into acc the next cycle.
// DRAIN gives the last p_sum its fold cycle before the result is presented in OUT.
module adder_accum_ctrl
   import adder_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   adder_accum_ctrl_if.slave bus
);

   state_e           state_q, state_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [SUM_W-1:0] p_sum_q, p_sum_d;
   logic             p_valid_q, p_valid_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [SUM_W-1:0] lane_sum;
   logic             beat;
   logic             job_start;

   adder_16b_20b u_adder (
      .data (bus.s_data),
      .sum  (lane_sum)
   );

   assign beat      = bus.s_valid && (state_q == StRun);
   assign job_start = bus.start && (state_q == StIdle);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         StIdle: begin
            if (bus.start) begin
               // len=0 wraps through 255 on the first beat, giving 256 beats.
               cnt_d   = bus.len;
               state_d = StRun;
            end
         end
         StRun: begin
            if (beat) begin
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == LEN_W'(1)) state_d = StDrain;
            end
         end
         StDrain: state_d = StOut;
         StOut:   if (bus.m_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      p_valid_d = beat;
      p_sum_d   = p_sum_q;
      acc_d     = acc_q;
      if (job_start) begin
         p_sum_d = '0;
         acc_d   = '0;
      end else begin
         if (beat)      p_sum_d = lane_sum;
         if (p_valid_q) acc_d   = acc_q + sext_sum(p_sum_q);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         p_sum_q   <= '0;
         p_valid_q <= 1'b0;
         acc_q     <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         p_sum_q   <= p_sum_d;
         p_valid_q <= p_valid_d;
         acc_q     <= acc_d;
      end
   end

   // Outputs depend on registered state only.
   assign bus.s_ready = (state_q == StRun);
   assign bus.m_valid = (state_q == StOut);
   assign bus.busy    = (state_q != StIdle);
   assign bus.m_data  = acc_q;

endmodule

// File: doc/adder_accum_ctrl.md
ADDER_ACCUM_CTRL -- requirements
Module: adder_accum_ctrl

Interface
REQ-001 Clock and reset: one clock, clk; reset is asynchronous and active-high, named reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high; clears all state.
REQ-004 start  input  1  pulse; begins a reduction job; sampled only in IDLE.
REQ-005 len  input  8  beats in the job, sampled with start; 0 means 256.
REQ-006 s_valid  input  1  input beat valid.
REQ-007 s_data  input  256  16 signed 16-bit lanes; lane i = bits [16i+15:16i].
REQ-008 s_ready  output  1  block accepts a beat; a beat transfers when s_valid && s_ready.
REQ-009 m_valid  output  1  result valid; held until accepted.
REQ-010 m_data  output  28  signed job sum.
REQ-011 m_ready  input  1  result accepted when m_valid && m_ready.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 States: IDLE, RUN, DRAIN, OUT; any unused encoding returns to IDLE.
REQ-014 IDLE: s_ready=0, m_valid=0; on start=1, latch len into beat counter, clear accumulator and pipeline register, go to RUN.
REQ-015 start is ignored in RUN, DRAIN and OUT, including a start coincident with the m_ready handshake.
REQ-016 RUN: s_ready=1; each accepted beat is summed by the lane adder (16 lanes to signed 20-bit, sign-correct), registered into p_sum with p_valid=1 one cycle later.
REQ-017 Accumulate stage: when p_valid=1, acc <= acc + sign-extend(p_sum) to 28 bits; no saturation; 28 bits cannot overflow for 256 beats of 16 lanes of 16 bits.
REQ-018 Beat counter decrements on each accepted beat; the beat that brings it to 0 moves RUN to DRAIN in the next cycle.
REQ-019 Cycles with s_valid=0 in RUN are bubbles: no counter change, p_valid=0 next cycle.
REQ-020 DRAIN: s_ready=0; lasts exactly one cycle so the last p_sum is folded into acc; then OUT.
REQ-021 Latency: last beat accepted at cycle t -> m_valid=1 at cycle t+2 (registered), m_data = final acc.
REQ-022 OUT: m_valid=1, m_data stable until m_ready=1; on handshake go to IDLE with m_valid=0 the next cycle.
REQ-023 len=1: single beat; len=0: exactly 256 beats accepted before DRAIN.
REQ-024 All outputs are registered or decoded from state only; no combinational path from s_data to any output.

Reset
REQ-025 On reset: state=IDLE, s_ready=0, m_valid=0, m_data=0, busy=0, acc=0, p_sum=0, p_valid=0, beat counter=0.
REQ-026 Reset asserted mid-job aborts it; no result is produced, and the first post-reset job is unaffected by the aborted job.

Structure
REQ-027 Shared package adder_pkg holds LANES=16, LANE_W=16, SUM_W=20, ACC_W=28, LEN_W=8 and the state enum type.
REQ-028 The 16-lane to 20-bit combinational sum is one sub-module, adder_16b_20b, instantiated once; all sequencing stays in adder_accum_ctrl.

Verification
REQ-029 Reset, then start, len=1, one beat with all lanes=16'h0001 -> m_valid at t+2, m_data=16; m_ready=1 -> IDLE, busy=0.
REQ-030 len=4, all lanes=16'h8000 for 4 beats, s_valid toggling 1,0,1,1,0,1 -> exactly 4 beats accepted, m_data=-2^21 (28'hFE00000).
REQ-031 len=0, 256 beats all lanes=16'h7FFF -> 256 beats accepted, then DRAIN, m_data=256*16*32767=134213632.
REQ-032 Result pending with m_ready=0 for 5 cycles, start pulsed during OUT -> m_data stable, start ignored, IDLE after handshake.
REQ-033 Reset asserted after 2 of 3 beats, then new job len=2 with lanes=1 -> m_data=32, no stale contribution.
REQ-034 Mixed signs, per beat lanes alternating +100/-100 for len=3 -> m_data=0; a random-data run is checked against a reference sum model.
